// File: rtl/ffinv_pkg.sv
// Shared types and constants for the byte-serial field-inverse sequencer.
// Holds the FSM state encoding, the datapath widths and the request mode encodings.
// The low_idx helper chooses the next pending byte when zero-skip is built in.
package ffinv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ffinv_state_t;

  localparam int FFINV_BYTE_W = 8;
  localparam int FFINV_WORD_W = 32;

  localparam logic FFINV_MODE_BYTE = 1'b0;
  localparam logic FFINV_MODE_WORD = 1'b1;

  // Returns the index of the lowest set bit. The result is 0 when no bit is set,
  // but callers only use it while at least one byte is pending.
  function automatic logic [1:0] ffinv_low_idx(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ffinv_lut1.sv
// Single-byte table stage shared by byte-wise and word-wise ffinv operations.
// Purely combinational. Entry k of this table image holds k.
// Only din[7:0] selects the entry. dout[31:8] is always zero.
module ffinv_lut1
  import ffinv_pkg::*;
(
  input  logic [FFINV_WORD_W-1:0] din,
  output logic [FFINV_WORD_W-1:0] dout
);

  logic unused_din_hi;

  // The upper operand bits are zero-extension only and carry no information.
  assign unused_din_hi = ^din[FFINV_WORD_W-1:FFINV_BYTE_W];

  // Table read. The table is indexed by the selected operand byte.
  always_comb begin
    dout = '0;
    dout[FFINV_BYTE_W-1:0] = din[FFINV_BYTE_W-1:0];
  end

endmodule

// File: rtl/ffinv_seq.sv
// Byte-serial sequencer feeding one operand byte per cycle into a shared ffinv_lut1.
// Latency: mode 0 -> rsp 2 cycles after accept; mode 1 -> NBYTES+1 (variable 1..5 with FFINV_SEQ_ZERO_SKIP_EN).
// Backpressure: the result is held in DONE until rsp_ready. A new request is taken in the same cycle as that handshake.
module ffinv_seq
  import ffinv_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [FFINV_WORD_W-1:0] req_data,
  input  logic                    req_mode,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FFINV_WORD_W-1:0] rsp_data,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NBYTES);

  ffinv_state_t                          state;
  logic [NBYTES-1:0][FFINV_BYTE_W-1:0]   opnd;
  logic [NBYTES-1:0][FFINV_BYTE_W-1:0]   result;
  logic [IDX_W-1:0]                      cur_idx;
  logic [FFINV_BYTE_W-1:0]               cur_byte;
  logic [FFINV_WORD_W-1:0]               lut_in;
  logic [FFINV_WORD_W-1:0]               lut_out;
  logic                                  last;
  logic                                  accept;
  logic                                  unused_lut_hi;

`ifdef FFINV_SEQ_ZERO_SKIP_EN
  logic [NBYTES-1:0][FFINV_BYTE_W-1:0]   req_bytes;
  logic [NBYTES-1:0]                     pend;
  logic [NBYTES-1:0]                     pend_nxt;
  logic [NBYTES-1:0]                     acc_mask;

  assign req_bytes = req_data;

  // Build the set of bytes that need a table cycle. Zero bytes are left as 0 in the result.
  always_comb begin
    acc_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      acc_mask[i] = (req_bytes[i] != '0) && ((req_mode == FFINV_MODE_WORD) || (i == 0));
    end
  end

  // Serve the lowest pending byte. The operation completes when nothing is left pending after it.
  always_comb begin
    cur_idx           = ffinv_low_idx(pend);
    pend_nxt          = pend;
    pend_nxt[cur_idx] = 1'b0;
    last              = (pend_nxt == '0);
  end
`else
  logic [IDX_W-1:0] idx;
  logic             mode;

  // Walk bytes in order. Byte mode stops after byte 0.
  always_comb begin
    cur_idx = idx;
    last    = (mode == FFINV_MODE_WORD) ? (idx == IDX_W'(NBYTES - 1)) : (idx == '0);
  end
`endif

  assign req_ready = !rst && !flush && ((state == IDLE) || ((state == DONE) && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign rsp_data  = result;

  assign cur_byte = opnd[cur_idx];
  assign lut_in   = {{(FFINV_WORD_W - FFINV_BYTE_W){1'b0}}, cur_byte};

  ffinv_lut1 u_lut (
    .din  (lut_in),
    .dout (lut_out)
  );

  // Only the low byte of the table output is meaningful.
  assign unused_lut_hi = ^lut_out[FFINV_WORD_W-1:FFINV_BYTE_W];

  // Control FSM with registered outputs. A new accept overrides the DONE->IDLE exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      opnd      <= '0;
      result    <= '0;
`ifdef FFINV_SEQ_ZERO_SKIP_EN
      pend      <= '0;
`else
      idx       <= '0;
      mode      <= FFINV_MODE_BYTE;
`endif
    end else if (flush) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        RUN: begin
          result[cur_idx] <= lut_out[FFINV_BYTE_W-1:0];
`ifdef FFINV_SEQ_ZERO_SKIP_EN
          pend <= pend_nxt;
`else
          if (!last) idx <= idx + 1'b1;
`endif
          if (last) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        opnd   <= req_data;
        result <= '0;
`ifdef FFINV_SEQ_ZERO_SKIP_EN
        pend   <= acc_mask;
        if (acc_mask == '0) begin
          state     <= DONE;
          rsp_valid <= 1'b1;
          busy      <= 1'b0;
        end else begin
          state     <= RUN;
          rsp_valid <= 1'b0;
          busy      <= 1'b1;
        end
`else
        mode      <= req_mode;
        idx       <= '0;
        state     <= RUN;
        rsp_valid <= 1'b0;
        busy      <= 1'b1;
`endif
      end
    end
  end

endmodule
